// File: rtl/spi_dac_single_channel.sv
// Button-triggered SPI writer for a single-channel DAC: one rising edge on
// button_i sends one NBITS-bit frame of DATA, MSB first, SPI mode 0.
module spi_dac_single_channel #(
   parameter int               NBITS = 24,
   parameter logic [NBITS-1:0] DATA  = 24'h30_8000,
   parameter int               DIV   = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic button_i,
   output logic mosi_o,
   output logic sck_o,
   output logic cs_o,
   output logic eow_o
);

   localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   state_t           r_state, w_nxt;
   logic             r_sync1, r_sync2, r_btn_d;
   logic [NBITS-1:0] r_shreg;
   logic [BW-1:0]    r_bit;
   logic [DW-1:0]    r_div;
   logic             r_sck, r_cs, r_eow;
   logic             w_start, w_phase_end, w_last;

   assign w_start     = r_sync2 & ~r_btn_d;
   assign w_phase_end = (r_div == DW'(DIV - 1));
   assign w_last      = (r_bit == BW'(NBITS - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_btn_d <= 1'b0;
      end else begin
         r_sync1 <= button_i;
         r_sync2 <= r_sync1;
         r_btn_d <= r_sync2;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_nxt = S_LOAD;
         S_LOAD:  w_nxt = S_SHIFT;
         S_SHIFT: if (w_phase_end && r_sck && w_last) w_nxt = S_DONE;
         S_DONE:  w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they change on the same
   // edge as the state and never glitch.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_shreg <= '0;
         r_bit   <= '0;
         r_div   <= '0;
         r_sck   <= 1'b0;
         r_cs    <= 1'b1;
         r_eow   <= 1'b0;
      end else begin
         r_cs  <= !(w_nxt == S_LOAD || w_nxt == S_SHIFT);
         r_eow <= (w_nxt == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (w_nxt == S_LOAD) r_shreg <= DATA;
               r_bit <= '0;
               r_div <= '0;
               r_sck <= 1'b0;
            end
            S_LOAD: begin
               r_bit <= '0;
               r_div <= '0;
               r_sck <= 1'b0;
            end
            S_SHIFT: begin
               if (w_phase_end) begin
                  r_div <= '0;
                  r_sck <= ~r_sck;
                  // End of a high phase: SCK falls and the next bit appears.
                  if (r_sck) begin
                     r_shreg <= {r_shreg[NBITS-2:0], 1'b0};
                     if (!w_last) r_bit <= r_bit + BW'(1);
                  end
               end else begin
                  r_div <= r_div + DW'(1);
               end
            end
            default: begin
               r_shreg <= '0;
               r_sck   <= 1'b0;
            end
         endcase
      end
   end

   assign mosi_o = r_shreg[NBITS-1];
   assign sck_o  = r_sck;
   assign cs_o   = r_cs;
   assign eow_o  = r_eow;

endmodule

// File: tb/tb_spi_dac_single_channel.sv
// Directed bench for spi_dac_single_channel: default instance plus an
// instance with DATA=0xA55A0F, DIV=1.
module tb_spi_dac_single_channel;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_a = 1'b0, btn_b = 1'b0;
   logic mosi_a, sck_a, cs_a, eow_a;
   logic mosi_b, sck_b, cs_b, eow_b;

   int nchk = 0;
   int nerr = 0;
   int eow_cnt_a = 0;
   int csfall_a = 0;
   logic prev_cs_a = 1'b1;

   always #5 clk = ~clk;

   spi_dac_single_channel dut_a (
      .clk_i(clk), .rst_i(rst), .button_i(btn_a),
      .mosi_o(mosi_a), .sck_o(sck_a), .cs_o(cs_a), .eow_o(eow_a)
   );

   spi_dac_single_channel #(.DATA(24'hA5_5A0F), .DIV(1)) dut_b (
      .clk_i(clk), .rst_i(rst), .button_i(btn_b),
      .mosi_o(mosi_b), .sck_o(sck_b), .cs_o(cs_b), .eow_o(eow_b)
   );

   always @(negedge clk) begin
      if (eow_a === 1'b1) eow_cnt_a++;
      if (prev_cs_a === 1'b1 && cs_a === 1'b0) csfall_a++;
      prev_cs_a = cs_a;
   end

   // Watches one frame from the press onward; all counts are in clk cycles.
   task automatic capture(input bit sel, input int budget,
                          output logic [23:0] word, output int nedge,
                          output int cslow, output int lat,
                          output int first_rise, output int period,
                          output logic load_mosi, output int neow,
                          output logic eow_rise, output longint t_end,
                          output bit tmo);
      logic c, s, m, e, ps;
      bit started, done;
      int last_rise;
      word = '0; nedge = 0; cslow = 0; lat = 0; first_rise = 0; period = 0;
      load_mosi = 1'bx; neow = 0; eow_rise = 1'b0; t_end = 0;
      started = 0; done = 0; ps = 1'b0; last_rise = 0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         c = sel ? cs_b : cs_a;
         s = sel ? sck_b : sck_a;
         m = sel ? mosi_b : mosi_a;
         e = sel ? eow_b : eow_a;
         if (!started) begin
            lat++;
            if (c === 1'b0) started = 1;
         end
         if (c === 1'b0) begin
            cslow++;
            if (cslow == 1) load_mosi = m;
            if (s === 1'b1 && ps === 1'b0) begin
               nedge++;
               word = {word[22:0], m};
               if (first_rise == 0) first_rise = cslow;
               else period = cslow - last_rise;
               last_rise = cslow;
            end
         end
         if (e === 1'b1) neow++;
         if (started && c === 1'b1) begin
            eow_rise = e;
            t_end = $time;
            done = 1;
         end
         ps = s;
      end
      tmo = !done;
   endtask

   task automatic test_reset;
      #10 rst = 1'b0;
      #1;
      nchk++; if (cs_a !== 1'b1)   begin nerr++; $display("FAIL reset_cs: got %b exp 1", cs_a); end
      nchk++; if (sck_a !== 1'b0)  begin nerr++; $display("FAIL reset_sck: got %b exp 0", sck_a); end
      nchk++; if (mosi_a !== 1'b0) begin nerr++; $display("FAIL reset_mosi: got %b exp 0", mosi_a); end
      nchk++; if (eow_a !== 1'b0)  begin nerr++; $display("FAIL reset_eow: got %b exp 0", eow_a); end
   endtask

   task automatic test_single_press;
      logic [23:0] w; int ne, cl, lt, fr, pr, nw; logic lm, er; longint te; bit to;
      @(negedge clk); @(negedge clk);
      fork
         begin btn_a = 1'b1; @(negedge clk); btn_a = 1'b0; end
         capture(1'b0, 300, w, ne, cl, lt, fr, pr, lm, nw, er, te, to);
      join
      nchk++; if (to !== 1'b0)       begin nerr++; $display("FAIL single_timeout: got %b exp 0", to); end
      nchk++; if (lt != 3)           begin nerr++; $display("FAIL single_latency: got %0d exp 3", lt); end
      nchk++; if (w !== 24'h308000)  begin nerr++; $display("FAIL single_word: got %h exp 308000", w); end
      nchk++; if (ne != 24)          begin nerr++; $display("FAIL single_edges: got %0d exp 24", ne); end
      nchk++; if (cl != 97)          begin nerr++; $display("FAIL single_cs_low: got %0d exp 97", cl); end
      nchk++; if (fr != 4)           begin nerr++; $display("FAIL single_first_rise: got %0d exp 4", fr); end
      nchk++; if (pr != 4)           begin nerr++; $display("FAIL single_sck_period: got %0d exp 4", pr); end
      nchk++; if (lm !== 1'b0)       begin nerr++; $display("FAIL single_load_mosi: got %b exp 0", lm); end
      nchk++; if (nw != 1)           begin nerr++; $display("FAIL single_eow_count: got %0d exp 1", nw); end
      nchk++; if (er !== 1'b1)       begin nerr++; $display("FAIL single_eow_at_cs_rise: got %b exp 1", er); end
      nchk++; if (te >= 2030)        begin nerr++; $display("FAIL single_end_time: got %0d exp <2030", te); end
   endtask

   task automatic test_idle;
      int bad = 0;
      int f0 = csfall_a;
      repeat (200) begin
         @(negedge clk);
         if (cs_a !== 1'b1 || sck_a !== 1'b0 || mosi_a !== 1'b0 || eow_a !== 1'b0) bad++;
      end
      nchk++; if (bad != 0)         begin nerr++; $display("FAIL idle_activity: got %0d exp 0", bad); end
      nchk++; if (csfall_a != f0)   begin nerr++; $display("FAIL idle_cs_fall: got %0d exp %0d", csfall_a, f0); end
   endtask

   task automatic test_held;
      logic [23:0] w; int ne, cl, lt, fr, pr, nw; logic lm, er; longint te; bit to;
      int f0 = csfall_a;
      int e0 = eow_cnt_a;
      fork
         begin btn_a = 1'b1; repeat (300) @(negedge clk); btn_a = 1'b0; end
         capture(1'b0, 300, w, ne, cl, lt, fr, pr, lm, nw, er, te, to);
      join
      repeat (20) @(negedge clk);
      nchk++; if (w !== 24'h308000)      begin nerr++; $display("FAIL held_word: got %h exp 308000", w); end
      nchk++; if (csfall_a - f0 != 1)    begin nerr++; $display("FAIL held_frames: got %0d exp 1", csfall_a - f0); end
      nchk++; if (eow_cnt_a - e0 != 1)   begin nerr++; $display("FAIL held_eow: got %0d exp 1", eow_cnt_a - e0); end
   endtask

   task automatic test_busy_ignore;
      logic [23:0] w; int ne, cl, lt, fr, pr, nw; logic lm, er; longint te; bit to;
      int e0 = eow_cnt_a;
      fork
         begin
            btn_a = 1'b1; @(negedge clk); btn_a = 1'b0;
            repeat (30) @(negedge clk);
            btn_a = 1'b1; @(negedge clk); btn_a = 1'b0;
         end
         capture(1'b0, 300, w, ne, cl, lt, fr, pr, lm, nw, er, te, to);
      join
      repeat (20) @(negedge clk);
      nchk++; if (w !== 24'h308000)     begin nerr++; $display("FAIL busy_word: got %h exp 308000", w); end
      nchk++; if (ne != 24)             begin nerr++; $display("FAIL busy_edges: got %0d exp 24", ne); end
      nchk++; if (eow_cnt_a - e0 != 1)  begin nerr++; $display("FAIL busy_eow: got %0d exp 1", eow_cnt_a - e0); end
      fork
         begin btn_a = 1'b1; @(negedge clk); btn_a = 1'b0; end
         capture(1'b0, 300, w, ne, cl, lt, fr, pr, lm, nw, er, te, to);
      join
      nchk++; if (w !== 24'h308000)     begin nerr++; $display("FAIL busy_second_word: got %h exp 308000", w); end
      nchk++; if (cl != 97)             begin nerr++; $display("FAIL busy_second_cs_low: got %0d exp 97", cl); end
   endtask

   task automatic test_reset_midframe;
      logic [23:0] w; int ne, cl, lt, fr, pr, nw; logic lm, er; longint te; bit to;
      int n = 0;
      int e0;
      logic ps = 1'b0;
      @(negedge clk);
      fork
         begin btn_a = 1'b1; @(negedge clk); btn_a = 1'b0; end
         for (int i = 0; i < 200 && n < 10; i++) begin
            @(negedge clk);
            if (sck_a === 1'b1 && ps === 1'b0) n++;
            ps = sck_a;
         end
      join
      nchk++; if (n != 10) begin nerr++; $display("FAIL midrst_reach_edge10: got %0d exp 10", n); end
      e0 = eow_cnt_a;
      rst = 1'b1;
      #1;
      nchk++; if (cs_a !== 1'b1)  begin nerr++; $display("FAIL midrst_cs: got %b exp 1", cs_a); end
      nchk++; if (sck_a !== 1'b0) begin nerr++; $display("FAIL midrst_sck: got %b exp 0", sck_a); end
      @(negedge clk);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      nchk++; if (eow_cnt_a != e0) begin nerr++; $display("FAIL midrst_no_eow: got %0d exp %0d", eow_cnt_a, e0); end
      fork
         begin btn_a = 1'b1; @(negedge clk); btn_a = 1'b0; end
         capture(1'b0, 300, w, ne, cl, lt, fr, pr, lm, nw, er, te, to);
      join
      nchk++; if (w !== 24'h308000) begin nerr++; $display("FAIL midrst_after_word: got %h exp 308000", w); end
      nchk++; if (nw != 1)          begin nerr++; $display("FAIL midrst_after_eow: got %0d exp 1", nw); end
   endtask

   task automatic test_param;
      logic [23:0] w; int ne, cl, lt, fr, pr, nw; logic lm, er; longint te; bit to;
      @(negedge clk);
      fork
         begin btn_b = 1'b1; @(negedge clk); btn_b = 1'b0; end
         capture(1'b1, 200, w, ne, cl, lt, fr, pr, lm, nw, er, te, to);
      join
      nchk++; if (to !== 1'b0)      begin nerr++; $display("FAIL param_timeout: got %b exp 0", to); end
      nchk++; if (w !== 24'hA55A0F) begin nerr++; $display("FAIL param_word: got %h exp a55a0f", w); end
      nchk++; if (ne != 24)         begin nerr++; $display("FAIL param_edges: got %0d exp 24", ne); end
      nchk++; if (cl != 49)         begin nerr++; $display("FAIL param_cs_low: got %0d exp 49", cl); end
      nchk++; if (pr != 2)          begin nerr++; $display("FAIL param_sck_period: got %0d exp 2", pr); end
      nchk++; if (fr != 3)          begin nerr++; $display("FAIL param_first_rise: got %0d exp 3", fr); end
      nchk++; if (lm !== 1'b1)      begin nerr++; $display("FAIL param_load_mosi: got %b exp 1", lm); end
      nchk++; if (nw != 1)          begin nerr++; $display("FAIL param_eow: got %0d exp 1", nw); end
   endtask

   initial begin
      test_reset;
      test_single_press;
      test_idle;
      test_held;
      test_busy_ignore;
      test_reset_midframe;
      test_param;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
      $finish;
   end

endmodule
